// File: rtl/stopwatch_bcd.sv
// stopwatch_bcd: three-key MM:SS.CC BCD stopwatch; optional lap freeze when STOPWATCH_LAP_EN is defined.
// Latency: key edge -> state change after 2 sync + DEBOUNCE_CYCLES + 1 cycles; counter -> value 1 cycle.
// Backpressure: none; keys sampled every cycle, outputs always valid.
module stopwatch_bcd #(
    parameter int CLK_HZ          = 50000000,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start_stop_n,
    input  logic        lap_n,
    input  logic        clear_n,
    output logic [31:0] value,
    output logic        running,
    output logic        lap_active
);
    localparam int DIV = CLK_HZ / 100;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int DW  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
    localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    // Per-digit terminal values, least significant digit first: cc, ss (x9/x5), mm (x9/x5).
    localparam logic [23:0] DIGIT_MAX  = 24'h595999;

    typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

    // Key index 0 = start_stop, 1 = clear, 2 = lap (lap only exists when the feature is built).
`ifdef STOPWATCH_LAP_EN
    localparam int NK = 3;
    logic [NK-1:0] key_raw;
    assign key_raw = {lap_n, clear_n, start_stop_n};
`else
    localparam int NK = 2;
    logic [NK-1:0] key_raw;
    logic          unused_lap;
    assign key_raw    = {clear_n, start_stop_n};
    assign unused_lap = lap_n;
`endif

    logic [NK-1:0] press;

    for (genvar k = 0; k < NK; k++) begin : g_key
        logic          meta;
        logic          sync;
        logic          level;
        logic          pulse;
        logic [DW-1:0] db_cnt;

        // Two-flop synchronizer, then accept a new level after DEBOUNCE_CYCLES equal samples; pulse on 1->0.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                meta   <= 1'b1;
                sync   <= 1'b1;
                level  <= 1'b1;
                pulse  <= 1'b0;
                db_cnt <= '0;
            end else begin
                meta  <= key_raw[k];
                sync  <= meta;
                pulse <= 1'b0;
                if (sync == level) begin
                    db_cnt <= '0;
                end else if (db_cnt == DB_LAST) begin
                    db_cnt <= '0;
                    level  <= sync;
                    pulse  <= ~sync;
                end else begin
                    db_cnt <= db_cnt + DW'(1);
                end
            end
        end

        assign press[k] = pulse;
    end

    logic ss_ev;
    logic clr_ev;
    assign ss_ev  = press[0];
    assign clr_ev = press[1];

    state_t        state;
    logic [PW-1:0] presc;
    logic [23:0]   cnt;
    logic [23:0]   cnt_inc;
    logic          carry;
    logic          tick;

    assign tick = (state == RUN) && (presc == PRE_LAST);

    // BCD ripple increment of all six digits; each digit wraps at its own terminal value.
    always_comb begin
        cnt_inc = cnt;
        carry   = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (carry) begin
                if (cnt[i*4 +: 4] == DIGIT_MAX[i*4 +: 4]) begin
                    cnt_inc[i*4 +: 4] = 4'd0;
                end else begin
                    cnt_inc[i*4 +: 4] = cnt[i*4 +: 4] + 4'd1;
                    carry             = 1'b0;
                end
            end
        end
    end

    // Control FSM with prescaler and counters; clear overrides everything, pause keeps the prescaler phase.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            running <= 1'b0;
            presc   <= '0;
            cnt     <= '0;
        end else if (clr_ev) begin
            state   <= IDLE;
            running <= 1'b0;
            presc   <= '0;
            cnt     <= '0;
        end else begin
            if (state == RUN) begin
                if (tick) begin
                    presc <= '0;
                    cnt   <= cnt_inc;
                end else begin
                    presc <= presc + PW'(1);
                end
            end
            if (ss_ev) begin
                case (state)
                    RUN: begin
                        state   <= PAUSE;
                        running <= 1'b0;
                    end
                    default: begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                endcase
            end
        end
    end

`ifdef STOPWATCH_LAP_EN
    logic        lap_ev;
    logic        lap_set;
    logic        lap_rel;
    logic [23:0] snap;

    assign lap_ev  = press[2];
    // Lap is judged against the state before any same-cycle start_stop transition.
    assign lap_set = lap_ev && !clr_ev && (state == RUN) && !lap_active;
    assign lap_rel = lap_ev && !clr_ev && (state == RUN) &&  lap_active;

    // Display register: frozen snapshot while lap is active, otherwise the live counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lap_active <= 1'b0;
            snap       <= '0;
            value      <= '0;
        end else if (clr_ev) begin
            lap_active <= 1'b0;
            value      <= {8'h00, cnt};
        end else if (lap_set) begin
            lap_active <= 1'b1;
            snap       <= cnt;
            value      <= {8'h00, cnt};
        end else if (lap_rel) begin
            lap_active <= 1'b0;
            value      <= {8'h00, cnt};
        end else begin
            value      <= {8'h00, (lap_active ? snap : cnt)};
        end
    end
`else
    assign lap_active = 1'b0;

    // Display register tracks the counters one cycle behind.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            value <= '0;
        end else begin
            value <= {8'h00, cnt};
        end
    end
`endif

endmodule
